// File: rtl/imem_loader_if.sv
// imem_loader bus bundle: the host byte stream (valid/ready) and the
// instruction-memory write port.
//   slave  : the loader side (consumes bytes, drives the write port)
//   master : the environment side (byte source and memory sink)
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: program loader for the instruction memory.
//
// A load session starts with a single-cycle start pulse. The first byte is
// the word count N (1..DEPTH). The following 4*N bytes are packed
// little-endian into 32-bit words and written to consecutive word
// addresses 0, 4, 8, ... The core is held in reset (cpu_hold) for the
// whole session. A bad count or a gap of TIMEOUT_CYCLES cycles without a
// transfer aborts the session and raises the sticky error flag.
//
// Optional feature, macro IMEM_LOADER_CHKSUM_EN: after the last word, one
// further byte is accepted and compared with the XOR of all data bytes.
// A mismatch aborts the session. Words already written stay written.
module imem_loader #(
    parameter int DEPTH          = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COUNT  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam logic [2:0] ST_CHECK  = 3'd6;
`endif

    // Idle-cycle counter is wide enough to hold TIMEOUT_CYCLES itself.
    localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [2:0]       state_q,    state_d;
    logic [7:0]       count_q,    count_d;     // N latched from the count byte
    logic [7:0]       word_cnt_q, word_cnt_d;  // words written this session
    logic [1:0]       byte_cnt_q, byte_cnt_d;  // byte lane of the next data byte
    logic [TMO_W-1:0] tmo_q,      tmo_d;       // cycles since the last transfer
    logic [31:0]      waddr_q,    waddr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             error_q,    error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]       chk_q,      chk_d;       // running XOR of data bytes
`endif

    // ------------------------------------------------------------------
    // Handshake and timeout
    // ------------------------------------------------------------------
    logic rx_ready_w;
    logic xfer;
    logic tmo_expire;

    // The loader listens for bytes exactly in the states that consume them.
`ifdef IMEM_LOADER_CHKSUM_EN
    assign rx_ready_w = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                        (state_q == ST_CHECK);
`else
    assign rx_ready_w = (state_q == ST_COUNT) || (state_q == ST_DATA);
`endif

    assign xfer = bus.rx_valid && rx_ready_w;

    // Idle counter: runs only while waiting for a byte, restarts on a transfer.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise
        // the paths that do not assign it would infer a latch.
        tmo_d      = '0;
        tmo_expire = 1'b0;
        if (rx_ready_w && !xfer) begin
            if (tmo_q == TMO_LAST) begin
                tmo_expire = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Session sequencing, byte packing and address stepping.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_d      = chk_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_COUNT;
                    error_d    = 1'b0;
                    count_d    = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    waddr_d    = '0;
                    wdata_d    = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d      = '0;
`endif
                end
            end

            ST_COUNT: begin
                if (xfer) begin
                    if ((bus.rx_data == 8'd0) || (int'(bus.rx_data) > DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        count_d = bus.rx_data;
                        state_d = ST_DATA;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d      = chk_q ^ bus.rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end

            // Write strobe is up for this single cycle; address steps after it.
            ST_WRITE: begin
                waddr_d    = waddr_q + 32'd4;
                word_cnt_d = word_cnt_q + 8'd1;
                if ((word_cnt_q + 8'd1) == count_q) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FINISH;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end

`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (bus.rx_data == chk_q) ? ST_FINISH : ST_ERR;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
`endif

            ST_FINISH: state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Error is raised on the way into ERR so it is visible during the
        // ERR cycle and stays up until the next accepted start.
        if (state_d == ST_ERR) begin
            error_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers with synchronous active-low reset
    // ------------------------------------------------------------------
    // Register update; reset discards any partially assembled word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign bus.rx_ready   = rx_ready_w;
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign cpu_hold       = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FINISH);
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (DEPTH=64, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// Builds with or without IMEM_LOADER_CHKSUM_EN.
module tb_imem_loader;
    localparam int DEPTH = 64;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold;
    logic busy;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Two-word program: count, then addi x2,x0,5 and addi x3,x0,10.
    logic [7:0] prog [9] = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00,
                             8'h93, 8'h01, 8'hA0, 8'h00};

    // Write-port monitor.
    int          wr_cnt;
    int          done_cnt;
    int          rdy_in_we;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = bus.imem_waddr;
                wr_data[wr_cnt] = bus.imem_wdata;
            end
            wr_cnt++;
            if (bus.rx_ready !== 1'b0) rdy_in_we++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt    = 0;
        done_cnt  = 0;
        rdy_in_we = 0;
        for (int i = 0; i < 8; i++) begin
            wr_addr[i] = 32'hDEAD_BEEF;
            wr_data[i] = 32'hDEAD_BEEF;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a byte and hold it until it is accepted; rx_valid is left high.
    task automatic send(input logic [7:0] b);
        bit acc = 1'b0;
        int n   = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = (bus.rx_ready === 1'b1);
            @(negedge clk);
            n++;
        end
        check("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] prog_xor();
        logic [7:0] x = 8'h00;
        for (int i = 1; i < 9; i++) x ^= prog[i];
        return x;
    endfunction

    // Count byte plus eight data bytes, with or without gaps between bytes.
    task automatic load(input bit gapped, input string tag);
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 9; i++) begin
            send(prog[i]);
            if (i == 4 || i == 8) begin
                check({tag, "_we_latency"}, 32'(bus.imem_we), 32'd1);
            end
            if (gapped) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_load(input string tag);
`ifdef IMEM_LOADER_CHKSUM_EN
        send(prog_xor());
`endif
        bus.rx_valid = 1'b0;
        wait_idle(tag);
    endtask

    task automatic verify_two_words(input string tag);
        check({tag, "_wr_cnt"},  32'(wr_cnt), 32'd2);
        check({tag, "_addr0"},   wr_addr[0], 32'h0000_0000);
        check({tag, "_data0"},   wr_data[0], 32'h0050_0113);
        check({tag, "_addr1"},   wr_addr[1], 32'h0000_0004);
        check({tag, "_data1"},   wr_data[1], 32'h00A0_0193);
        check({tag, "_done"},    32'(done_cnt), 32'd1);
        check({tag, "_error"},   32'(error), 32'd0);
        check({tag, "_hold"},    32'(cpu_hold), 32'd0);
        check({tag, "_rdy_we"},  32'(rdy_in_we), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_we"},       32'(bus.imem_we), 32'd0);
        check({tag, "_waddr"},    bus.imem_waddr, 32'd0);
        check({tag, "_wdata"},    bus.imem_wdata, 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_hold"},     32'(cpu_hold), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
        check({tag, "_error"},    32'(error), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Two-word load with idle cycles between bytes.
        clear_mon();
        load(1'b1, "gap");
        finish_load("gap");
        verify_two_words("gap");

        // Bad count 0x00, then restart (clears error) with count 0x41 > DEPTH.
        clear_mon();
        pulse_start();
        send(8'h00);
        bus.rx_valid = 1'b0;
        check("cnt00_error", 32'(error), 32'd1);
        @(negedge clk);
        check("cnt00_busy", 32'(busy), 32'd0);
        pulse_start();
        check("restart_clears_error", 32'(error), 32'd0);
        send(8'h41);
        bus.rx_valid = 1'b0;
        check("cnt41_error", 32'(error), 32'd1);
        @(negedge clk);
        check("cnt41_busy", 32'(busy), 32'd0);
        check("badcnt_no_we", 32'(wr_cnt), 32'd0);
        check("badcnt_no_done", 32'(done_cnt), 32'd0);

        // Back-pressure: rx_valid held high across the whole load.
        clear_mon();
        load(1'b0, "bp");
        finish_load("bp");
        verify_two_words("bp");

        // Timeout: count 01 and two data bytes, then silence.
        clear_mon();
        pulse_start();
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        bus.rx_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("tmo_15_error", 32'(error), 32'd0);
        check("tmo_15_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("tmo_16_error", 32'(error), 32'd1);
        @(negedge clk);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_hold", 32'(cpu_hold), 32'd0);
        check("tmo_no_we", 32'(wr_cnt), 32'd0);

        // Reset clears the sticky error.
        reset = 1'b0;
        @(negedge clk);
        check("rst_clears_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-session after the third data byte.
        clear_mon();
        pulse_start();
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        bus.rx_valid = 1'b0;
        check("pre_rst_wdata", bus.imem_wdata, 32'h0033_2211);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b1;
        @(negedge clk);
        check("midrst_no_we", 32'(wr_cnt), 32'd0);

        // A fresh session after the reset loads correctly.
        clear_mon();
        load(1'b0, "post");
        finish_load("post");
        verify_two_words("post");

`ifdef IMEM_LOADER_CHKSUM_EN
        // Wrong checksum: both words written, then abort.
        clear_mon();
        load(1'b0, "badsum");
        send(prog_xor() ^ 8'hFF);
        bus.rx_valid = 1'b0;
        check("badsum_error", 32'(error), 32'd1);
        wait_idle("badsum");
        check("badsum_wr_cnt", 32'(wr_cnt), 32'd2);
        check("badsum_done", 32'(done_cnt), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
